// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ttt_pkg
// Brief    : Shared encodings, board type and win-line table for tic-tac-toe
// Revision : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] S_WAIT = 2'b00;
    localparam logic [1:0] S_USER = 2'b01;
    localparam logic [1:0] S_CPU  = 2'b10;
    localparam logic [1:0] S_OVER = 2'b11;

    typedef logic [8:0][1:0] board_t;

    // Line n occupies c_win_lines[n]; rows, then columns, then diagonals
    localparam logic [7:0][2:0][3:0] c_win_lines = {
        4'd2, 4'd4, 4'd6,
        4'd0, 4'd4, 4'd8,
        4'd2, 4'd5, 4'd8,
        4'd1, 4'd4, 4'd7,
        4'd0, 4'd3, 4'd6,
        4'd6, 4'd7, 4'd8,
        4'd3, 4'd4, 4'd5,
        4'd0, 4'd1, 4'd2
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_USER  = 3'd1,
        ST_CPU   = 3'd2,
        ST_CHECK = 3'd3,
        ST_OVER  = 3'd4
    } ctrl_state_t;

    function automatic logic [1:0] other_symbol(input logic [1:0] sym);
        return (sym == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : game_controller_if
// Brief    : Player handshake and board bus around the game controller
// Revision : 1.0 - initial release
// ============================================================================
interface game_controller_if;
    import ttt_pkg::*;

    logic         start;
    logic         user_first;
    logic         user_indicator;
    logic         user_done;
    board_t       vector_after_user;
    logic         cpu_done;
    board_t       vector_after_cpu;
    board_t       main_vector;
    logic [1:0]   state;
    logic [1:0]   winner;
    logic         game_over;
    logic [3:0]   move_count;
    logic         illegal_move;

    modport slave (
        input  start, user_first, user_indicator,
        input  user_done, vector_after_user, cpu_done, vector_after_cpu,
        output main_vector, state, winner, game_over, move_count, illegal_move
    );

    modport master (
        output start, user_first, user_indicator,
        output user_done, vector_after_user, cpu_done, vector_after_cpu,
        input  main_vector, state, winner, game_over, move_count, illegal_move
    );

endinterface
`default_nettype wire

// File: rtl/board_judge.sv
`default_nettype none
// ============================================================================
// Module   : board_judge
// Brief    : Combinational win / full detection on a committed board
// Revision : 1.0 - initial release
// ============================================================================
module board_judge
    import ttt_pkg::*;
(
    input  board_t     board,
    input  logic [3:0] move_count,
    output logic       win,
    output logic [1:0] win_symbol,
    output logic       full
);

    logic [7:0]      w_line_hit;
    logic [7:0][1:0] w_line_sym;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            logic [1:0] w_a;
            logic [1:0] w_b;
            logic [1:0] w_c;
            assign w_a = board[c_win_lines[gi][0]];
            assign w_b = board[c_win_lines[gi][1]];
            assign w_c = board[c_win_lines[gi][2]];
            assign w_line_hit[gi] = (w_a != CELL_EMPTY) && (w_a == w_b) && (w_a == w_c);
            assign w_line_sym[gi] = w_a;
        end
    endgenerate

    always_comb begin
        win        = |w_line_hit;
        win_symbol = CELL_EMPTY;
        for (int i = 7; i >= 0; i--) begin
            if (w_line_hit[i]) begin
                win_symbol = w_line_sym[i];
            end
        end
    end

    assign full = (move_count >= 4'd9);

endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Brief    : Tic-tac-toe turn scheduler, move validator and board owner
// Revision : 1.0 - initial release
// ============================================================================
module game_controller
    import ttt_pkg::*;
#(
    parameter int MOVE_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    game_controller_if.slave bus
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;

    board_t     r_board;
    logic [3:0] r_move_count;
    logic [1:0] r_winner;
    logic [1:0] r_user_sym;
    logic       r_illegal;
    logic       r_last_user;

    logic       w_in_turn;
    logic       w_expire;
    logic       w_mover_done;
    board_t     w_prop;
    logic [1:0] w_mover_sym;
    logic [3:0] w_diff_cnt;
    logic       w_diff_ok;
    logic       w_legal;
    logic       w_commit;
    logic       w_illegal;
    logic       w_new_game;
    logic       w_end_game;
    logic       w_win;
    logic [1:0] w_win_symbol;
    logic       w_full;
    logic [1:0] w_state_code;

    assign w_in_turn = (r_state == ST_USER) || (r_state == ST_CPU);

    always_comb begin
        w_mover_done = 1'b0;
        w_prop       = bus.vector_after_cpu;
        w_mover_sym  = other_symbol(r_user_sym);
        if (r_state == ST_USER) begin
            w_mover_done = bus.user_done;
            w_prop       = bus.vector_after_user;
            w_mover_sym  = r_user_sym;
        end else if (r_state == ST_CPU) begin
            w_mover_done = bus.cpu_done;
        end
    end

    // Legal means exactly one changed cell, previously empty, now the mover's symbol
    always_comb begin
        w_diff_cnt = 4'd0;
        w_diff_ok  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (w_prop[i] != r_board[i]) begin
                w_diff_cnt = w_diff_cnt + 4'd1;
                if ((r_board[i] != CELL_EMPTY) || (w_prop[i] != w_mover_sym)) begin
                    w_diff_ok = 1'b0;
                end
            end
        end
        w_legal = (w_diff_cnt == 4'd1) && w_diff_ok;
    end

    board_judge u_board_judge (
        .board      (r_board),
        .move_count (r_move_count),
        .win        (w_win),
        .win_symbol (w_win_symbol),
        .full       (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_illegal    = 1'b0;
        w_new_game   = 1'b0;
        w_end_game   = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    w_new_game   = 1'b1;
                    w_state_next = bus.user_first ? ST_USER : ST_CPU;
                end
            end
            ST_USER, ST_CPU: begin
                // A done flag wins over a timeout expiring on the same edge
                if (w_mover_done) begin
                    if (w_legal) begin
                        w_commit     = 1'b1;
                        w_state_next = ST_CHECK;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_next = (r_state == ST_USER) ? ST_CPU : ST_USER;
                end
            end
            ST_CHECK: begin
                if (w_win || w_full) begin
                    w_end_game   = 1'b1;
                    w_state_next = ST_OVER;
                end else begin
                    w_state_next = r_last_user ? ST_CPU : ST_USER;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board      <= '0;
            r_move_count <= 4'd0;
            r_winner     <= CELL_EMPTY;
            r_user_sym   <= CELL_X;
            r_illegal    <= 1'b0;
            r_last_user  <= 1'b0;
        end else begin
            r_illegal <= w_illegal;
            if (w_new_game) begin
                r_board      <= '0;
                r_move_count <= 4'd0;
                r_winner     <= CELL_EMPTY;
                r_user_sym   <= bus.user_indicator ? CELL_X : CELL_O;
            end
            if (w_commit) begin
                r_board      <= w_prop;
                r_move_count <= (r_move_count == 4'd9) ? 4'd9 : r_move_count + 4'd1;
                r_last_user  <= (r_state == ST_USER);
            end
            if (w_end_game) begin
                r_winner <= w_win ? w_win_symbol : CELL_EMPTY;
            end
        end
    end

    generate
        if (MOVE_TIMEOUT > 0) begin : g_timeout
            localparam int c_tw = (MOVE_TIMEOUT > 1) ? $clog2(MOVE_TIMEOUT) : 1;
            logic [c_tw-1:0] r_tmo_cnt;

            // Holds across rejected moves; clears whenever the state changes
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tmo_cnt <= '0;
                end else if (w_in_turn && (w_state_next == r_state)) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end else begin
                    r_tmo_cnt <= '0;
                end
            end

            assign w_expire = w_in_turn && (r_tmo_cnt == c_tw'(MOVE_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        case (r_state)
            ST_USER: w_state_code = S_USER;
            ST_CPU:  w_state_code = S_CPU;
            ST_OVER: w_state_code = S_OVER;
            default: w_state_code = S_WAIT;
        endcase
    end

    assign bus.main_vector  = r_board;
    assign bus.state        = w_state_code;
    assign bus.winner       = r_winner;
    assign bus.game_over    = (r_state == ST_OVER);
    assign bus.move_count   = r_move_count;
    assign bus.illegal_move = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_controller
// Brief    : Vector-table and directed-sequence bench for game_controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_controller;
    import ttt_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    game_controller_if bus0();
    game_controller_if bus_t();

    game_controller #(.MOVE_TIMEOUT(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    game_controller #(.MOVE_TIMEOUT(4)) u_dut_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_t.slave)
    );

    typedef struct {
        logic       st;
        logic       uf;
        logic       ui;
        logic       ud;
        board_t     uv;
        logic       cd;
        board_t     cv;
        logic [1:0] es;
        int         emc;
        logic       eill;
        board_t     eb;
        logic [1:0] ew;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    string E = ".........";

    function automatic board_t bd(input string s);
        board_t b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (s[i] == "X") b[i] = CELL_X;
            else if (s[i] == "O") b[i] = CELL_O;
        end
        return b;
    endfunction

    function automatic void add(input logic st, input logic uf, input logic ui,
                                input logic ud, input string uv,
                                input logic cd, input string cv,
                                input logic [1:0] es, input int emc, input logic eill,
                                input string eb, input logic [1:0] ew);
        vec_t v;
        v.st = st;  v.uf = uf;  v.ui = ui;
        v.ud = ud;  v.uv = bd(uv);
        v.cd = cd;  v.cv = bd(cv);
        v.es = es;  v.emc = emc; v.eill = eill;
        v.eb = bd(eb); v.ew = ew;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        bus0.start = 1'b0; bus0.user_first = 1'b0; bus0.user_indicator = 1'b0;
        bus0.user_done = 1'b0; bus0.cpu_done = 1'b0;
        bus0.vector_after_user = '0; bus0.vector_after_cpu = '0;
        bus_t.start = 1'b0; bus_t.user_first = 1'b0; bus_t.user_indicator = 1'b0;
        bus_t.user_done = 1'b0; bus_t.cpu_done = 1'b0;
        bus_t.vector_after_user = '0; bus_t.vector_after_cpu = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state",   32'(bus0.state),        32'(S_WAIT));
        chk("reset.board",   32'(bus0.main_vector),  32'd0);
        chk("reset.mc",      32'(bus0.move_count),   32'd0);
        chk("reset.winner",  32'(bus0.winner),       32'd0);
        chk("reset.over",    32'(bus0.game_over),    32'd0);
        chk("reset.illegal", 32'(bus0.illegal_move), 32'd0);
        rst_n = 1'b1;

        // Game 1: user X first, ends in a draw
        add(1,1,1, 0,E,0,E,                   S_USER,0,0,E,CELL_EMPTY);
        add(0,0,0, 1,"X........",0,E,         S_WAIT,1,0,"X........",CELL_EMPTY);
        add(0,0,0, 1,"X........",0,E,         S_CPU, 1,0,"X........",CELL_EMPTY);
        add(0,0,0, 0,E,1,"X...O....",         S_WAIT,2,0,"X...O....",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_USER,2,0,"X...O....",CELL_EMPTY);
        add(0,0,0, 1,"X...X....",0,E,         S_USER,2,1,"X...O....",CELL_EMPTY);
        add(0,0,0, 1,"X.O.O....",0,E,         S_USER,2,1,"X...O....",CELL_EMPTY);
        add(0,0,0, 0,E,1,"XX..O....",         S_USER,2,0,"X...O....",CELL_EMPTY);
        add(0,0,0, 1,"X.X.O....",0,E,         S_WAIT,3,0,"X.X.O....",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_CPU, 3,0,"X.X.O....",CELL_EMPTY);
        add(0,0,0, 0,E,1,"XOX.O....",         S_WAIT,4,0,"XOX.O....",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_USER,4,0,"XOX.O....",CELL_EMPTY);
        add(0,0,0, 1,"XOX.O..X.",0,E,         S_WAIT,5,0,"XOX.O..X.",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_CPU, 5,0,"XOX.O..X.",CELL_EMPTY);
        add(0,0,0, 0,E,1,"XOX.O.OX.",         S_WAIT,6,0,"XOX.O.OX.",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_USER,6,0,"XOX.O.OX.",CELL_EMPTY);
        add(0,0,0, 1,"XOXXO.OX.",0,E,         S_WAIT,7,0,"XOXXO.OX.",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_CPU, 7,0,"XOXXO.OX.",CELL_EMPTY);
        add(0,0,0, 0,E,1,"XOXXOOOX.",         S_WAIT,8,0,"XOXXOOOX.",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_USER,8,0,"XOXXOOOX.",CELL_EMPTY);
        add(0,0,0, 1,"XOXXOOOXX",0,E,         S_WAIT,9,0,"XOXXOOOXX",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_OVER,9,0,"XOXXOOOXX",CELL_EMPTY);
        add(0,0,0, 1,E,1,E,                   S_OVER,9,0,"XOXXOOOXX",CELL_EMPTY);
        // Game 2: computer (X) first, wins on the top row
        add(1,0,0, 0,E,0,E,                   S_CPU, 0,0,E,CELL_EMPTY);
        add(0,0,0, 0,E,1,"X........",         S_WAIT,1,0,"X........",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_USER,1,0,"X........",CELL_EMPTY);
        add(0,0,0, 1,"X...O....",0,E,         S_WAIT,2,0,"X...O....",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_CPU, 2,0,"X...O....",CELL_EMPTY);
        add(0,0,0, 0,E,1,"XX..O....",         S_WAIT,3,0,"XX..O....",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_USER,3,0,"XX..O....",CELL_EMPTY);
        add(0,0,0, 1,"XX..O...O",0,E,         S_WAIT,4,0,"XX..O...O",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_CPU, 4,0,"XX..O...O",CELL_EMPTY);
        add(0,0,0, 0,E,1,"XXX.O...O",         S_WAIT,5,0,"XXX.O...O",CELL_EMPTY);
        add(0,0,0, 0,E,0,E,                   S_OVER,5,0,"XXX.O...O",CELL_X);

        for (int k = 0; k < tbl.size(); k++) begin
            bus0.start             = tbl[k].st;
            bus0.user_first        = tbl[k].uf;
            bus0.user_indicator    = tbl[k].ui;
            bus0.user_done         = tbl[k].ud;
            bus0.vector_after_user = tbl[k].uv;
            bus0.cpu_done          = tbl[k].cd;
            bus0.vector_after_cpu  = tbl[k].cv;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.state", k),   32'(bus0.state),        32'(tbl[k].es));
            chk($sformatf("v%0d.mc", k),      32'(bus0.move_count),   32'(tbl[k].emc));
            chk($sformatf("v%0d.illegal", k), 32'(bus0.illegal_move), 32'(tbl[k].eill));
            chk($sformatf("v%0d.board", k),   32'(bus0.main_vector),  32'(tbl[k].eb));
            chk($sformatf("v%0d.winner", k),  32'(bus0.winner),       32'(tbl[k].ew));
            chk($sformatf("v%0d.over", k),    32'(bus0.game_over),    32'(tbl[k].es == S_OVER));
        end

        // Done pulses from both players are ignored once the game is over
        bus0.start = 1'b0;
        bus0.user_done = 1'b1; bus0.vector_after_user = bd("XXXOO...O");
        bus0.cpu_done  = 1'b1; bus0.vector_after_cpu  = bd("XXX.OX..O");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("over%0d.state", i), 32'(bus0.state),       32'(S_OVER));
            chk($sformatf("over%0d.board", i), 32'(bus0.main_vector), 32'(bd("XXX.O...O")));
        end
        chk("over.winner", 32'(bus0.winner),     32'(CELL_X));
        chk("over.mc",     32'(bus0.move_count), 32'd5);

        // Asynchronous reset in the middle of the computer's turn
        bus0.user_done = 1'b0; bus0.cpu_done = 1'b0;
        bus0.start = 1'b1; bus0.user_first = 1'b1; bus0.user_indicator = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus0.user_done = 1'b1; bus0.vector_after_user = bd("....X....");
        @(posedge clk); #1;
        bus0.user_done = 1'b0;
        @(posedge clk); #1;
        chk("rst.pre_state", 32'(bus0.state),      32'(S_CPU));
        chk("rst.pre_mc",    32'(bus0.move_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.state",   32'(bus0.state),        32'(S_WAIT));
        chk("rst.board",   32'(bus0.main_vector),  32'd0);
        chk("rst.mc",      32'(bus0.move_count),   32'd0);
        chk("rst.winner",  32'(bus0.winner),       32'd0);
        chk("rst.over",    32'(bus0.game_over),    32'd0);
        chk("rst.illegal", 32'(bus0.illegal_move), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.idle", 32'(bus0.state), 32'(S_WAIT));

        // Timeout instance: idle user forfeits after 4 cycles, then the CPU
        // moves on the very edge its own timeout would expire
        bus_t.start = 1'b1; bus_t.user_first = 1'b1; bus_t.user_indicator = 1'b1;
        @(posedge clk); #1;
        bus_t.start = 1'b0;
        chk("tmo.user0", 32'(bus_t.state), 32'(S_USER));
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("tmo.user%0d", i), 32'(bus_t.state), 32'(S_USER));
        end
        @(posedge clk); #1;
        chk("tmo.to_cpu", 32'(bus_t.state),       32'(S_CPU));
        chk("tmo.mc",     32'(bus_t.move_count),  32'd0);
        chk("tmo.board",  32'(bus_t.main_vector), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("tmo.cpu%0d", i), 32'(bus_t.state), 32'(S_CPU));
        end
        bus_t.cpu_done = 1'b1; bus_t.vector_after_cpu = bd("O........");
        @(posedge clk); #1;
        bus_t.cpu_done = 1'b0;
        chk("tmo.race_state", 32'(bus_t.state),       32'(S_WAIT));
        chk("tmo.race_mc",    32'(bus_t.move_count),  32'd1);
        chk("tmo.race_board", 32'(bus_t.main_vector), 32'(bd("O........")));
        @(posedge clk); #1;
        chk("tmo.next_user", 32'(bus_t.state), 32'(S_USER));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
